// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS subset sequencer: FETCH/DECODE/EXECUTE/WRITEBACK/BRANCH control and PC/IR state.
// Define MIPS_SEQ_JR_EN to make JR (R-type funct 001000) legal; otherwise JR decodes as illegal.
module mips_seq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_BRANCH    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    K_ALU,
    K_BRANCH,
    K_JR,
    K_ILLEGAL
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLT   = 6'h0A;
  localparam logic [5:0] OP_BGT   = 6'h0B;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [5:0] F_JR     = 6'h08;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        imem_req_q, imem_req_d;

  kind_e       dec_kind;
  logic [1:0]  dec_alu_op;
  logic        dec_alu_src;
  logic        br_taken;
  logic [31:0] pc_seq;
  logic [31:0] br_target;

  logic [5:0]  opcode;
  logic [5:0]  funct;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  // Decode is purely a function of IR, so operands stay stable from DECODE to the end of the instruction.
  always_comb begin
    dec_kind    = K_ILLEGAL;
    dec_alu_op  = ALU_ADD;
    dec_alu_src = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD: begin dec_kind = K_ALU; dec_alu_op = ALU_ADD; end
          F_SUB: begin dec_kind = K_ALU; dec_alu_op = ALU_SUB; end
          F_AND: begin dec_kind = K_ALU; dec_alu_op = ALU_AND; end
          F_SLT: begin dec_kind = K_ALU; dec_alu_op = ALU_SLT; end
`ifdef MIPS_SEQ_JR_EN
          F_JR:  dec_kind = K_JR;
`endif
          default: dec_kind = K_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        dec_kind    = K_ALU;
        dec_alu_op  = ALU_ADD;
        dec_alu_src = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_kind   = K_BRANCH;
        dec_alu_op = ALU_SUB;
      end
      OP_BLT, OP_BGT: begin
        dec_kind   = K_BRANCH;
        dec_alu_op = ALU_SLT;
      end
      default: dec_kind = K_ILLEGAL;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BEQ:  br_taken = alu_zero;
      OP_BNE:  br_taken = !alu_zero;
      OP_BLT:  br_taken = alu_lt;
      OP_BGT:  br_taken = !alu_lt && !alu_zero;
      default: br_taken = 1'b0;
    endcase
  end

  // Natural 32-bit wrap gives the modulo-2^32 PC behaviour.
  assign pc_seq    = pc_q + 32'd4;
  assign br_target = pc_seq + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_kind == K_ILLEGAL) begin
          pc_d    = pc_seq;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = (dec_kind == K_ALU) ? S_WRITEBACK : S_BRANCH;
      end
      S_WRITEBACK: begin
        pc_d    = pc_seq;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (dec_kind == K_JR)
          pc_d = rs_data;
        else if (br_taken)
          pc_d = br_target;
        else
          pc_d = pc_seq;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Registered so the request stays low during reset and rises on the first edge after release.
    imem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign instr      = ir_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign alu_src    = dec_alu_src;
  assign alu_op     = dec_alu_op;
  assign reg_write  = (state_q == S_WRITEBACK);
  assign illegal_op = (state_q == S_DECODE) && (dec_kind == K_ILLEGAL);

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Randomized self-checking bench for mips_seq_ctrl against an instruction-level reference model.
module tb_mips_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic        alu_zero;
  logic        alu_lt;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        illegal_op;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  mips_seq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .rs_data    (rs_data),
    .pc         (pc),
    .state      (state),
    .illegal_op (illegal_op)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: instruction class 0=ALU write, 1=conditional branch, 2=JR, 3=illegal.
  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] op;
    logic       src;
  } ref_dec_t;

  function automatic ref_dec_t ref_decode(input logic [31:0] w);
    ref_dec_t d;
    d.kind = 2'd3;
    d.op   = 2'd0;
    d.src  = 1'b0;
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20: begin d.kind = 2'd0; d.op = 2'd0; end
        6'h22: begin d.kind = 2'd0; d.op = 2'd1; end
        6'h24: begin d.kind = 2'd0; d.op = 2'd2; end
        6'h2A: begin d.kind = 2'd0; d.op = 2'd3; end
`ifdef MIPS_SEQ_JR_EN
        6'h08: d.kind = 2'd2;
`endif
        default: ;
      endcase
    end else begin
      case (w[31:26])
        6'h08: begin d.kind = 2'd0; d.op = 2'd0; d.src = 1'b1; end
        6'h04, 6'h05: begin d.kind = 2'd1; d.op = 2'd1; end
        6'h0A, 6'h0B: begin d.kind = 2'd1; d.op = 2'd3; end
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] w,
                                              input logic z, input logic lt, input logic [31:0] rs);
    ref_dec_t d;
    logic taken;
    logic [31:0] off;
    d   = ref_decode(w);
    off = {{16{w[15]}}, w[15:0]};
    taken = (w[31:26] == 6'h04 && z) || (w[31:26] == 6'h05 && !z) ||
            (w[31:26] == 6'h0A && lt) || (w[31:26] == 6'h0B && !lt && !z);
    if (d.kind == 2'd2) return rs;
    if (d.kind == 2'd1 && taken) return cur + 32'd4 + off * 32'd4;
    return cur + 32'd4;
  endfunction

  function automatic logic [31:0] exp_state(input logic [1:0] kind, input int step);
    if (step == 0) return 32'd1;
    if (step == 1) return 32'd2;
    return (kind == 2'd0) ? 32'd3 : 32'd4;
  endfunction

  task automatic run_instr(input logic [31:0] w, input int waits, input logic z, input logic lt,
                           input logic [31:0] rs);
    ref_dec_t d;
    logic [31:0] npc;
    int steps;
    int nexp;
    logic done;
    d    = ref_decode(w);
    npc  = ref_next_pc(m_pc, w, z, lt, rs);
    nexp = (d.kind == 2'd3) ? 1 : 3;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk_eq("fetch_state", 32'(state), 32'd0);
      chk_eq("fetch_req", 32'(imem_req), 32'd1);
      chk_eq("fetch_addr", imem_addr, m_pc);
      imem_ack   = (i == waits);
      imem_rdata = (i == waits) ? w : $urandom;
      alu_zero   = z;
      alu_lt     = lt;
      rs_data    = rs;
    end
    steps = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (state == 3'd0) begin
        done = 1'b1;
      end else if (steps >= 6) begin
        chk_eq("timeout", 32'(steps), 32'(nexp));
        done = 1'b1;
      end else begin
        chk_eq("state_seq", 32'(state), exp_state(d.kind, steps));
        chk_eq("instr", instr, w);
        chk_eq("req_off", 32'(imem_req), 32'd0);
        chk_eq("reg_write", 32'(reg_write), 32'(d.kind == 2'd0 && steps == 2));
        chk_eq("illegal_op", 32'(illegal_op), 32'(d.kind == 2'd3 && steps == 0));
        chk_eq("pc_stable", pc, m_pc);
        if (d.kind != 2'd3) begin
          chk_eq("alu_op", 32'(alu_op), 32'(d.op));
          chk_eq("alu_src", 32'(alu_src), 32'(d.src));
        end
        steps++;
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
    end
    imem_ack = 1'b0;
    chk_eq("latency", 32'(steps), 32'(nexp));
    chk_eq("next_pc", pc, npc);
    m_pc = npc;
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] f);
    return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, f};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'($urandom), 5'($urandom), imm};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] alu_f [4];
    logic [31:0] w;
    alu_f = '{6'h20, 6'h22, 6'h24, 6'h2A};
    reset_n    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    alu_zero   = 1'b0;
    alu_lt     = 1'b0;
    rs_data    = '0;
    m_pc       = '0;

    repeat (2) @(negedge clk);
    chk_eq("rst_state", 32'(state), 32'd0);
    chk_eq("rst_pc", pc, 32'd0);
    chk_eq("rst_ir", instr, 32'd0);
    chk_eq("rst_req", 32'(imem_req), 32'd0);
    chk_eq("rst_wr", 32'(reg_write), 32'd0);
    chk_eq("rst_ill", 32'(illegal_op), 32'd0);
    chk_eq("rst_src", 32'(alu_src), 32'd0);
    chk_eq("rst_op", 32'(alu_op), 32'd0);
    reset_n = 1'b1;
    #1 chk_eq("req_before_edge", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 chk_eq("req_first_edge", 32'(imem_req), 32'd1);

    // Long ack-less wait, then ADD; then ADD with an immediate ack.
    run_instr(32'h01095020, 5, 1'b0, 1'b0, 32'd0);
    chk_eq("add_pc4", pc, 32'h4);
    run_instr(32'h01095020, 0, 1'b0, 1'b0, 32'd0);

    // Branch to 0xFFFFFFFC, then wrap to 0.
    run_instr(32'h1022FFFC, 0, 1'b1, 1'b0, 32'd0);
    chk_eq("wrap_target", pc, 32'hFFFFFFFC);
    run_instr(32'h01095020, 1, 1'b0, 1'b0, 32'd0);
    chk_eq("wrap_zero", pc, 32'h0);

    // Reach 0x100, then BEQ with offset -1 taken and not taken.
    run_instr(32'h1022003F, 0, 1'b1, 1'b0, 32'd0);
    chk_eq("reach_100", pc, 32'h100);
    run_instr(32'h1022FFFF, 0, 1'b1, 1'b0, 32'd0);
    chk_eq("beq_taken", pc, 32'h100);
    run_instr(32'h1022FFFF, 0, 1'b0, 1'b0, 32'd0);
    chk_eq("beq_not_taken", pc, 32'h104);

    run_instr(32'hFC000000, 0, 1'b0, 1'b0, 32'd0);
    chk_eq("illegal_pc", pc, 32'h108);

    run_instr(32'h00600008, 0, 1'b0, 1'b0, 32'h2000);
`ifdef MIPS_SEQ_JR_EN
    chk_eq("jr_pc", pc, 32'h2000);
`else
    chk_eq("jr_pc", pc, 32'h10C);
`endif

    // Reset asserted while in WRITEBACK.
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h01095020;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 5 && state != 3'd3; i++) @(negedge clk);
    chk_eq("wb_reached", 32'(state), 32'd3);
    chk_eq("wb_strobe", 32'(reg_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_eq("wb_rst_wr", 32'(reg_write), 32'd0);
    chk_eq("wb_rst_pc", pc, 32'd0);
    chk_eq("wb_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_pc    = 32'd0;

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: w = mk_r(alu_f[$urandom_range(0, 3)]);
        1: w = mk_i(6'h08, 16'($urandom));
        2: w = mk_i(6'h04, 16'($urandom));
        3: w = mk_i(6'h05, 16'($urandom));
        4: w = mk_i(6'h0A, 16'($urandom));
        5: w = mk_i(6'h0B, 16'($urandom));
        6: w = mk_r(6'h08);
        7: w = mk_i(6'h3F, 16'($urandom));
        8: w = mk_r(6'($urandom));
        default: w = $urandom;
      endcase
      run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
